rs232_bus_master: RTL

//  Serial-driven bus initiator: the requester side of the read_q/write_q/read_dn/write_dn bus

---
 rtl/rs232_bus_master_if.sv | 38 +++
 rtl/rs232_bus_master.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rs232_bus_master_if.sv
// ============================================================================
// Module   : rs232_bus_master_if
// Purpose  : Byte-stream UART side and single-word bus side of the serial
//            bus master, bundled with initiator/responder modports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rs232_bus_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              read_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic              read_dn;
    logic              write_dn;

    modport master (
        input  rx_valid, rx_byte, tx_busy, addr_in, data_in, read_dn, write_dn,
        output tx_start, tx_data, addr_out, data_out, read_q, write_q
    );

    modport slave (
        output rx_valid, rx_byte, tx_busy, addr_in, data_in, read_dn, write_dn,
        input  tx_start, tx_data, addr_out, data_out, read_q, write_q
    );
endinterface

`default_nettype wire

// File: rtl/rs232_bus_master.sv
// ============================================================================
// Module   : rs232_bus_master
// Purpose  : Decodes 'R'/'W' byte commands from a UART receiver, issues one
//            bus read/write and returns the result bytes to a UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs232_bus_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  wire logic               clk,
    input  wire logic               clk_oe,
    input  wire logic               rst,
    rs232_bus_master_if.master      bus,
    output logic                    overrun
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_ADDR  = 3'd1,
        S_GET_DATA  = 3'd2,
        S_BUS_REQ   = 3'd3,
        S_SEND_RESP = 3'd4
    } state_t;

    localparam logic [7:0] c_cmd_rd   = 8'h52;
    localparam logic [7:0] c_cmd_wr   = 8'h57;
    localparam logic [7:0] c_resp_ok  = 8'h4B;
    localparam logic [7:0] c_resp_err = 8'h45;
    localparam int         c_tmo_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    state_t               r_state,   w_state_nxt;
    logic                 r_cmd_w,   w_cmd_w_nxt;
    logic [1:0]           r_cnt,     w_cnt_nxt;
    logic [31:0]          r_addr,    w_addr_nxt;
    logic [31:0]          r_wdata,   w_wdata_nxt;
    logic [c_tmo_w-1:0]   r_tmo,     w_tmo_nxt;
    logic [31:0]          r_resp,    w_resp_nxt;
    logic [2:0]           r_left,    w_left_nxt;
    logic                 r_ack_ph,  w_ack_ph_nxt;
    logic                 r_wait,    w_wait_nxt;
    logic                 r_tx_start, w_tx_start_nxt;
    logic [7:0]           r_tx_data, w_tx_data_nxt;
    logic                 r_overrun, w_overrun_nxt;

    logic [ADDR_W-1:0]    w_addr_bus;
    logic [DATA_W-1:0]    w_wdata_bus;
    logic [31:0]          w_din32;
    logic                 w_rd_act;
    logic                 w_wr_act;
    logic                 w_done;

    // Command fields are always 32 bits; adapt them to the bus widths.
    if (ADDR_W > 32) begin : g_addr_wide
        assign w_addr_bus = {{(ADDR_W-32){1'b0}}, r_addr};
    end else begin : g_addr_fit
        assign w_addr_bus = r_addr[ADDR_W-1:0];
    end

    if (DATA_W > 32) begin : g_data_wide
        assign w_wdata_bus = {{(DATA_W-32){1'b0}}, r_wdata};
        assign w_din32     = bus.data_in[31:0];
    end else if (DATA_W == 32) begin : g_data_exact
        assign w_wdata_bus = r_wdata;
        assign w_din32     = bus.data_in;
    end else begin : g_data_narrow
        assign w_wdata_bus = r_wdata[DATA_W-1:0];
        assign w_din32     = {{(32-DATA_W){1'b0}}, bus.data_in};
    end

    assign w_rd_act = (r_state == S_BUS_REQ) && !r_cmd_w;
    assign w_wr_act = (r_state == S_BUS_REQ) &&  r_cmd_w;
    assign w_done   = (r_cmd_w ? bus.write_dn : bus.read_dn) && (bus.addr_in == w_addr_bus);

    assign bus.read_q   = w_rd_act;
    assign bus.write_q  = w_wr_act;
    assign bus.addr_out = (w_rd_act || w_wr_act) ? w_addr_bus : '0;
    assign bus.data_out = w_wr_act ? w_wdata_bus : '0;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign overrun      = r_overrun;

    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_w_nxt    = r_cmd_w;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_tmo_nxt      = r_tmo;
        w_resp_nxt     = r_resp;
        w_left_nxt     = r_left;
        w_ack_ph_nxt   = r_ack_ph;
        w_wait_nxt     = r_wait;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_overrun_nxt  = r_overrun;

        case (r_state)
            S_IDLE: begin
                if (bus.rx_valid && (bus.rx_byte == c_cmd_rd || bus.rx_byte == c_cmd_wr)) begin
                    w_cmd_w_nxt = (bus.rx_byte == c_cmd_wr);
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (bus.rx_valid) begin
                    w_addr_nxt = {r_addr[23:0], bus.rx_byte};
                    w_cnt_nxt  = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_tmo_nxt   = '0;
                        w_state_nxt = r_cmd_w ? S_GET_DATA : S_BUS_REQ;
                    end
                end
            end
            S_GET_DATA: begin
                if (bus.rx_valid) begin
                    w_wdata_nxt = {r_wdata[23:0], bus.rx_byte};
                    w_cnt_nxt   = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_tmo_nxt   = '0;
                        w_state_nxt = S_BUS_REQ;
                    end
                end
            end
            S_BUS_REQ: begin
                if (bus.rx_valid) begin
                    w_overrun_nxt = 1'b1;
                end
                w_ack_ph_nxt = 1'b0;
                w_wait_nxt   = 1'b0;
                if (w_done) begin
                    w_resp_nxt  = r_cmd_w ? {c_resp_ok, 24'h0} : w_din32;
                    w_left_nxt  = r_cmd_w ? 3'd1 : 3'd4;
                    w_state_nxt = S_SEND_RESP;
                end else if (r_tmo == c_tmo_last) begin
                    w_resp_nxt  = {c_resp_err, 24'h0};
                    w_left_nxt  = 3'd1;
                    w_state_nxt = S_SEND_RESP;
                end else begin
                    w_tmo_nxt = r_tmo + c_tmo_w'(1);
                end
            end
            S_SEND_RESP: begin
                if (bus.rx_valid) begin
                    w_overrun_nxt = 1'b1;
                end
                // Pulse once the transmitter is idle, then give it up to two
                // cycles to raise busy before moving on to the next byte.
                if (!r_ack_ph) begin
                    if (!bus.tx_busy) begin
                        w_tx_start_nxt = 1'b1;
                        w_tx_data_nxt  = r_resp[31:24];
                        w_ack_ph_nxt   = 1'b1;
                        w_wait_nxt     = 1'b0;
                    end
                end else if (bus.tx_busy || r_wait) begin
                    w_resp_nxt   = {r_resp[23:0], 8'h00};
                    w_left_nxt   = r_left - 3'd1;
                    w_ack_ph_nxt = 1'b0;
                    if (r_left == 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_wait_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmd_w    <= 1'b0;
            r_cnt      <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_tmo      <= '0;
            r_resp     <= '0;
            r_left     <= 3'd0;
            r_ack_ph   <= 1'b0;
            r_wait     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_overrun  <= 1'b0;
        end else if (clk_oe) begin
            r_state    <= w_state_nxt;
            r_cmd_w    <= w_cmd_w_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_tmo      <= w_tmo_nxt;
            r_resp     <= w_resp_nxt;
            r_left     <= w_left_nxt;
            r_ack_ph   <= w_ack_ph_nxt;
            r_wait     <= w_wait_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

endmodule

`default_nettype wire
